// File: rtl/rob_param_if.sv
// Purpose: the reorder buffer's issue, writeback and retire/recovery signal bundle.
// Latency: wires only, no storage.
// Backpressure: rob_full is the only throttle; the issuer must not assume an issue was accepted while rob_full=1.
// Ports (master = decoder/CDB side, slave = reorder buffer):
//   issue_*   : allocation request and its tag/full responses
//   wb_*      : CDB result broadcast
//   commit_*  : in-order retirement toward the register file
//   flush*    : mispredict recovery
interface rob_param_if #(
  parameter int ROB_BIT = 4,
  parameter int REG_BIT = 5,
  parameter int XLEN    = 32
);
  logic               issue_valid;
  logic [1:0]         issue_type;
  logic [REG_BIT-1:0] issue_rd;
  logic [XLEN-1:0]    issue_pc;
  logic               issue_done;
  logic [XLEN-1:0]    issue_value;
  logic               issue_pred;
  logic [XLEN-1:0]    issue_alt_pc;
  logic [ROB_BIT-1:0] issue_tag;
  logic               rob_full;

  logic               wb_valid;
  logic [ROB_BIT-1:0] wb_tag;
  logic [XLEN-1:0]    wb_value;

  logic               commit_valid;
  logic [REG_BIT-1:0] commit_rd;
  logic [XLEN-1:0]    commit_value;
  logic [ROB_BIT-1:0] commit_tag;
  logic               flush;
  logic [XLEN-1:0]    flush_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pc, issue_done,
           issue_value, issue_pred, issue_alt_pc,
           wb_valid, wb_tag, wb_value,
    input  issue_tag, rob_full,
           commit_valid, commit_rd, commit_value, commit_tag, flush, flush_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pc, issue_done,
           issue_value, issue_pred, issue_alt_pc,
           wb_valid, wb_tag, wb_value,
    output issue_tag, rob_full,
           commit_valid, commit_rd, commit_value, commit_tag, flush, flush_pc
  );
endinterface

// File: rtl/rob_param.sv
// Purpose: parametrised reorder buffer; in-order allocate, out-of-order writeback, in-order retire with mispredict flush.
// Latency: an entry that is ready in registered state retires on the next edge (commit/flush are registered pulses).
// Backpressure: issues are dropped while rob_full=1; rdy_in=0 freezes all state and masks the pulses.
// Ports: clk_in (clock), rst_in (sync active-high reset), rdy_in (global enable),
//        rob_bus (rob_param_if.slave: issue, writeback, commit and flush groups).
// Optional: define ROB_PERF_CNT_EN to add perf_commits / perf_flushes counter outputs.
module rob_param #(
  parameter int ROB_BIT = 4,
  parameter int REG_BIT = 5,
  parameter int XLEN    = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  rob_param_if.slave  rob_bus
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0] perf_commits,
  output logic [31:0] perf_flushes
`endif
);

  localparam int DEPTH = 1 << ROB_BIT;
  localparam logic [ROB_BIT-1:0] PTR_ONE  = 1;
  localparam logic [ROB_BIT:0]   FULL_CNT = (ROB_BIT+1)'(DEPTH);

  typedef enum logic [1:0] {
    T_ALU    = 2'd0,
    T_BRANCH = 2'd1,
    T_STORE  = 2'd2,
    T_JALR   = 2'd3
  } itype_e;

  // Entry storage. Only busy/ready carry reset; payload is qualified by busy.
  logic [DEPTH-1:0]   busy_q;
  logic [DEPTH-1:0]   ready_q;
  logic [DEPTH-1:0]   pred_q;
  itype_e             type_q  [DEPTH];
  logic [REG_BIT-1:0] rd_q    [DEPTH];
  // value_q holds the retire value (ALU result, branch outcome in bit0, store
  // data, JALR link). alt_q holds the recovery PC: the predicted-wrong path for
  // a BRANCH, or the CDB-computed target for a JALR, so flush_pc is always alt_q.
  logic [XLEN-1:0]    value_q [DEPTH];
  logic [XLEN-1:0]    alt_q   [DEPTH];

  logic [ROB_BIT-1:0] head_q;
  logic [ROB_BIT-1:0] tail_q;
  logic [ROB_BIT:0]   count_q;

  logic               commit_valid_q;
  logic [REG_BIT-1:0] commit_rd_q;
  logic [XLEN-1:0]    commit_value_q;
  logic [ROB_BIT-1:0] commit_tag_q;
  logic               flush_q;
  logic [XLEN-1:0]    flush_pc_q;

  logic               rob_full_w;
  logic               issue_acc;
  logic               wb_hit;
  logic               head_go;
  itype_e             head_type;
  logic               redirect;
  logic               retire_pulse;
  logic [REG_BIT-1:0] commit_rd_d;
  logic [ROB_BIT:0]   cnt_inc;
  logic [ROB_BIT:0]   cnt_dec;

  // Recovery PCs arrive explicitly, so the instruction PC is not needed for
  // retirement; it is reduced into a named sink to keep it on the bus.
  logic unused_issue_pc;
  assign unused_issue_pc = ^rob_bus.issue_pc;

  assign rob_full_w = (count_q == FULL_CNT);
  assign issue_acc  = rob_bus.issue_valid && !rob_full_w;
  assign wb_hit     = rob_bus.wb_valid && busy_q[rob_bus.wb_tag];

  // Retirement decisions look only at registered entry state, so a writeback
  // to the head in cycle N retires at the earliest on the following edge.
  assign head_go   = busy_q[head_q] && ready_q[head_q];
  assign head_type = type_q[head_q];
  assign redirect  = head_go &&
                     ((head_type == T_JALR) ||
                      ((head_type == T_BRANCH) && (value_q[head_q][0] != pred_q[head_q])));

  // A redirecting instruction only shows on the commit port when it has a
  // link register to write (JALR with rd != 0).
  assign retire_pulse = head_go &&
                        (!redirect || ((head_type == T_JALR) && (rd_q[head_q] != '0)));

  assign commit_rd_d = ((head_type == T_ALU) || (head_type == T_JALR)) ? rd_q[head_q] : '0;

  assign cnt_inc = {{ROB_BIT{1'b0}}, issue_acc};
  assign cnt_dec = {{ROB_BIT{1'b0}}, head_go};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      // Pulses last one cycle and are forced low on a frozen cycle.
      commit_valid_q <= 1'b0;
      flush_q        <= 1'b0;
      if (rdy_in) begin
        if (retire_pulse) begin
          commit_valid_q <= 1'b1;
          commit_rd_q    <= commit_rd_d;
          commit_value_q <= value_q[head_q];
          commit_tag_q   <= head_q;
        end
        if (redirect) begin
          // Whole window is wrong-path: drop it together with anything that
          // tried to issue or write back on this same edge.
          flush_q    <= 1'b1;
          flush_pc_q <= alt_q[head_q];
          head_q     <= '0;
          tail_q     <= '0;
          count_q    <= '0;
          busy_q     <= '0;
        end else begin
          if (wb_hit) begin
            ready_q[rob_bus.wb_tag] <= 1'b1;
            if (type_q[rob_bus.wb_tag] == T_JALR)
              alt_q[rob_bus.wb_tag] <= rob_bus.wb_value;
            else
              value_q[rob_bus.wb_tag] <= rob_bus.wb_value;
          end
          if (head_go) begin
            busy_q[head_q] <= 1'b0;
            head_q         <= head_q + PTR_ONE;
          end
          // Tail never equals a retiring head here: that would need a full
          // buffer, and issues are refused while full.
          if (issue_acc) begin
            busy_q[tail_q]  <= 1'b1;
            ready_q[tail_q] <= rob_bus.issue_done;
            pred_q[tail_q]  <= rob_bus.issue_pred;
            type_q[tail_q]  <= itype_e'(rob_bus.issue_type);
            rd_q[tail_q]    <= rob_bus.issue_rd;
            value_q[tail_q] <= rob_bus.issue_value;
            alt_q[tail_q]   <= rob_bus.issue_alt_pc;
            tail_q          <= tail_q + PTR_ONE;
          end
          count_q <= count_q + cnt_inc - cnt_dec;
        end
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_commits <= '0;
      perf_flushes <= '0;
    end else if (rdy_in) begin
      if (retire_pulse) perf_commits <= perf_commits + 32'd1;
      if (redirect)     perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

  assign rob_bus.issue_tag    = tail_q;
  assign rob_bus.rob_full     = rob_full_w;
  assign rob_bus.commit_valid = commit_valid_q;
  assign rob_bus.commit_rd    = commit_rd_q;
  assign rob_bus.commit_value = commit_value_q;
  assign rob_bus.commit_tag   = commit_tag_q;
  assign rob_bus.flush        = flush_q;
  assign rob_bus.flush_pc     = flush_pc_q;

endmodule
